// File: rtl/tetris_pkg.sv
// Shared types for the tetris input controller: command codes, button
// indices, FSM state encodings and the issue-priority helper.
package tetris_pkg;

  // Command codes seen by the game core. The code value equals the button
  // index, so a pending-flag vector can be indexed directly by a code.
  typedef enum logic [1:0] {
    CTRL_RIGHT  = 2'b00,
    CTRL_DOWN   = 2'b01,
    CTRL_LEFT   = 2'b10,
    CTRL_ROTATE = 2'b11
  } ctrl_e;

  // Bit positions inside btn_raw and the pending-flag vector
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_ROTATE = 3;

  // Issue FSM states
  typedef enum logic [1:0] {
    ISS_IDLE = 2'b00,
    ISS_FIRE = 2'b01,
    ISS_GAP  = 2'b10
  } issue_state_e;

  // Per-button repeat FSM states
  typedef enum logic [1:0] {
    REP_RELEASED = 2'b00,
    REP_DELAY    = 2'b01,
    REP_REPEAT   = 2'b10,
    REP_HELD     = 2'b11
  } rep_state_e;

  // Highest-priority pending command: rotate > left > right > down.
  // Callers only use the result when at least one flag is set.
  function automatic ctrl_e pick_cmd(input logic [3:0] flags);
    ctrl_e cmd;
    if (flags[BTN_ROTATE]) begin
      cmd = CTRL_ROTATE;
    end else if (flags[BTN_LEFT]) begin
      cmd = CTRL_LEFT;
    end else if (flags[BTN_RIGHT]) begin
      cmd = CTRL_RIGHT;
    end else begin
      cmd = CTRL_DOWN;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button: 2-FF synchronizer, debounce counter and repeat FSM.
// event_o is a single-cycle request toward the pending flags.
module btn_conditioner
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned REPEAT_DELAY = 30000000,
  parameter int unsigned REPEAT_RATE  = 8000000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic event_o
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  rep_state_e    rep_state_q, rep_state_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          event_s;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
    end
  end

  // Debounce: flip only after DEBOUNCE_CYC consecutive differing cycles
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = sync_q[1];
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debounce and repeat state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      rep_state_q <= REP_RELEASED;
      rep_cnt_q   <= '0;
    end else begin
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_state_q <= rep_state_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  // Repeat FSM next state; a debounced release always wins
  always_comb begin
    rep_state_d = rep_state_q;
    rep_cnt_d   = rep_cnt_q;
    case (rep_state_q)
      REP_RELEASED: begin
        rep_cnt_d = '0;
        if (deb_q) begin
          rep_state_d = REPEAT_EN ? REP_DELAY : REP_HELD;
        end else begin
          rep_state_d = REP_RELEASED;
        end
      end
      REP_DELAY: begin
        if (!deb_q) begin
          rep_state_d = REP_RELEASED;
          rep_cnt_d   = '0;
        end else if (rep_cnt_q == DELAY_LAST) begin
          rep_state_d = REP_REPEAT;
          rep_cnt_d   = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      REP_REPEAT: begin
        if (!deb_q) begin
          rep_state_d = REP_RELEASED;
          rep_cnt_d   = '0;
        end else if (rep_cnt_q == RATE_LAST) begin
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      REP_HELD: begin
        rep_cnt_d = '0;
        if (!deb_q) begin
          rep_state_d = REP_RELEASED;
        end else begin
          rep_state_d = REP_HELD;
        end
      end
      default: begin
        rep_state_d = REP_RELEASED;
        rep_cnt_d   = '0;
      end
    endcase
  end

  // Repeat FSM output: press event, first repeat, later repeats
  always_comb begin
    event_s = 1'b0;
    case (rep_state_q)
      REP_RELEASED: event_s = deb_q;
      REP_DELAY:    event_s = deb_q && (rep_cnt_q == DELAY_LAST);
      REP_REPEAT:   event_s = deb_q && (rep_cnt_q == RATE_LAST);
      REP_HELD:     event_s = 1'b0;
      default:      event_s = 1'b0;
    endcase
  end

  assign event_o = event_s;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Command initiator for the tetris core: four conditioned buttons plus a
// gravity timer feed one pending flag per command; an issue FSM fires one
// strobe at a time and then holds off for CMD_GAP idle cycles.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned REPEAT_DELAY = 30000000,
  parameter int unsigned REPEAT_RATE  = 8000000,
  parameter int unsigned GRAVITY_CYC  = 50000000,
  parameter int unsigned CMD_GAP      = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_raw,
  input  logic       gravity_en,
  output logic       ctrl_valid,
  output logic [1:0] ctrl
);

  localparam int unsigned GW = $clog2(GRAVITY_CYC + 1);
  localparam int unsigned PW = $clog2(CMD_GAP + 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_CYC - 1);
  localparam logic [PW-1:0] GAP_LOAD  = PW'(CMD_GAP);

  logic [3:0]    btn_evt_s;
  logic [3:0]    evt_all_s;
  logic          grav_evt_s, grav_restart_s;
  logic [GW-1:0] grav_cnt_q, grav_cnt_d;
  logic [3:0]    flag_q, flag_d;
  logic          down_man_q, down_man_d;
  logic [3:0]    issue_mask_s;
  issue_state_e  state_q, state_d;
  logic [PW-1:0] gap_q, gap_d;
  ctrl_e         ctrl_q, ctrl_d;
  logic          ctrl_valid_q, ctrl_valid_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (gi != BTN_ROTATE)
    ) u_btn (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw_i (btn_raw[gi]),
      .event_o   (btn_evt_s[gi])
    );
  end

  // A down command restarts gravity in the cycle its strobe is on the wire
  assign grav_restart_s = (state_q == ISS_FIRE) && (ctrl_q == CTRL_DOWN);

  // Gravity timer: held at zero when disabled, restarted by any down strobe;
  // a tick coinciding with a restart is dropped since a down just went out
  always_comb begin
    grav_cnt_d = grav_cnt_q;
    grav_evt_s = 1'b0;
    if (!gravity_en) begin
      grav_cnt_d = '0;
    end else if (grav_restart_s) begin
      grav_cnt_d = '0;
    end else if (grav_cnt_q == GRAV_LAST) begin
      grav_cnt_d = '0;
      grav_evt_s = 1'b1;
    end else begin
      grav_cnt_d = grav_cnt_q + GW'(1);
    end
  end

  assign evt_all_s = btn_evt_s | {2'b00, grav_evt_s, 1'b0};

  // Pending flags: set-wins-over-issue merging; disabling gravity drops a
  // down request only when no manual down contributed to it
  always_comb begin
    flag_d     = (flag_q & ~issue_mask_s) | evt_all_s;
    down_man_d = (down_man_q & ~issue_mask_s[BTN_DOWN]) | btn_evt_s[BTN_DOWN];
    if (!gravity_en && !down_man_d) begin
      flag_d[BTN_DOWN] = 1'b0;
    end else begin
      flag_d[BTN_DOWN] = flag_d[BTN_DOWN];
    end
  end

  // Issue FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ISS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISS_IDLE: begin
        if (|flag_q) begin
          state_d = ISS_FIRE;
        end else begin
          state_d = ISS_IDLE;
        end
      end
      ISS_FIRE: state_d = ISS_GAP;
      ISS_GAP: begin
        if ((gap_q == PW'(1)) || (gap_q == '0)) begin
          state_d = ISS_IDLE;
        end else begin
          state_d = ISS_GAP;
        end
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  // Issue FSM outputs: pick and clear a flag, arm the strobe, run the gap
  always_comb begin
    issue_mask_s = 4'b0000;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = 1'b0;
    gap_d        = gap_q;
    case (state_q)
      ISS_IDLE: begin
        if (|flag_q) begin
          ctrl_d       = pick_cmd(flag_q);
          issue_mask_s = 4'b0001 << ctrl_d;
          ctrl_valid_d = 1'b1;
        end else begin
          ctrl_d = ctrl_q;
        end
      end
      ISS_FIRE: gap_d = GAP_LOAD;
      ISS_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - PW'(1);
        end else begin
          gap_d = '0;
        end
      end
      default: gap_d = '0;
    endcase
  end

  // Datapath registers; ctrl_valid is registered so it is high exactly in FIRE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_cnt_q   <= '0;
      flag_q       <= 4'b0000;
      down_man_q   <= 1'b0;
      gap_q        <= '0;
      ctrl_q       <= CTRL_RIGHT;
      ctrl_valid_q <= 1'b0;
    end else begin
      grav_cnt_q   <= grav_cnt_d;
      flag_q       <= flag_d;
      down_man_q   <= down_man_d;
      gap_q        <= gap_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
    end
  end

  assign ctrl_valid = ctrl_valid_q;
  assign ctrl       = ctrl_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: stimulus pushes expected
// {code, cycle} pairs; a negedge monitor pops one per observed strobe.
module tb_tetris_input_ctrl;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic       gravity_en = 1'b0;
  logic       ctrl_valid;
  logic [1:0] ctrl;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] code;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  tetris_input_ctrl #(
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (8),
    .GRAVITY_CYC  (50),
    .CMD_GAP      (6)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .gravity_en (gravity_en),
    .ctrl_valid (ctrl_valid),
    .ctrl       (ctrl)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after posedge k it reads k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_strobe(input logic [1:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (ctrl_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: ctrl=%b at cycle %0d, none expected", ctrl, cyc);
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (ctrl !== e.code) begin
          errors++;
          $display("FAIL strobe_code: got %b, expected %b (cycle %0d)", ctrl, e.code, cyc);
        end
        if (cyc != e.at) begin
          errors++;
          $display("FAIL strobe_cycle: got %0d, expected %0d (code %b)", cyc, e.at, e.code);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int m;

    // 1. Reset and idle
    #1 reset_n = 1'b0;
    #1;
    check("reset_valid", 32'(ctrl_valid), 32'd0);
    check("reset_ctrl", 32'(ctrl), 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(500);

    // 2. Bounce (never stable for 4 cycles), then a clean left press
    for (int i = 0; i < 6; i++) begin
      btn_raw[BTN_LEFT] = ~btn_raw[BTN_LEFT];
      wait_cyc(2);
    end
    wait_cyc(10);
    t = cyc;
    btn_raw[BTN_LEFT] = 1'b1;
    expect_strobe(2'b10, t + 8);
    wait_cyc(15);
    btn_raw[BTN_LEFT] = 1'b0;
    wait_cyc(30);

    // 3. Down auto-repeat, then release; rotate held never repeats
    t = cyc;
    btn_raw[BTN_DOWN] = 1'b1;
    expect_strobe(2'b01, t + 8);
    expect_strobe(2'b01, t + 28);
    expect_strobe(2'b01, t + 36);
    expect_strobe(2'b01, t + 44);
    wait_cyc(40);
    btn_raw[BTN_DOWN] = 1'b0;
    wait_cyc(40);
    t = cyc;
    btn_raw[BTN_ROTATE] = 1'b1;
    expect_strobe(2'b11, t + 8);
    wait_cyc(100);
    btn_raw[BTN_ROTATE] = 1'b0;
    wait_cyc(30);

    // 4. Rotate and right in the same cycle: rotate first, right one gap later
    t = cyc;
    btn_raw[BTN_ROTATE] = 1'b1;
    btn_raw[BTN_RIGHT]  = 1'b1;
    expect_strobe(2'b11, t + 8);
    expect_strobe(2'b00, t + 16);
    wait_cyc(10);
    btn_raw[BTN_ROTATE] = 1'b0;
    btn_raw[BTN_RIGHT]  = 1'b0;
    wait_cyc(30);

    // 5. Gravity every 52 cycles, manual down restarts it, disable stops it
    t = cyc;
    gravity_en = 1'b1;
    expect_strobe(2'b01, t + 51);
    expect_strobe(2'b01, t + 103);
    expect_strobe(2'b01, t + 155);
    wait_cyc(170);
    m = cyc;
    btn_raw[BTN_DOWN] = 1'b1;
    expect_strobe(2'b01, m + 8);
    expect_strobe(2'b01, m + 60);
    wait_cyc(10);
    btn_raw[BTN_DOWN] = 1'b0;
    wait_cyc(60);
    gravity_en = 1'b0;
    wait_cyc(150);
    check("gravity_cnt_off", 32'(dut.grav_cnt_q), 32'd0);

    // 6. Reset during FIRE with left and down still pending
    t = cyc;
    btn_raw = 4'b1110;
    expect_strobe(2'b11, t + 8);
    wait_cyc(8);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(ctrl_valid), 32'd0);
    check("midreset_ctrl", 32'(ctrl), 32'd0);
    btn_raw = 4'b0000;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(100);

    // Anything still queued never appeared
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_strobe: expected ctrl=%b at cycle %0d did not occur", e.code, e.at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tetris_input_ctrl.md
Name: tetris_input_ctrl

Overview:
Command initiator for the tetris game core. It turns four raw push-buttons and a gravity timer into single-cycle `ctrl_valid` pulses with a 2-bit `ctrl` code, which feed straight into the core's command port. The core has no ready signal and can stay busy for many cycles during line clear, so this block enforces a minimum spacing between commands. It also debounces the buttons, applies auto-repeat and arbitrates between simultaneous requests.

Parameters:
DEBOUNCE_CYC, 1000000, consecutive stable cycles required before a button change is accepted
REPEAT_DELAY, 30000000, hold cycles from an accepted press to the first auto-repeat
REPEAT_RATE, 8000000, cycles between later auto-repeats
GRAVITY_CYC, 50000000, gravity period in cycles (emits one down command)
CMD_GAP, 256, idle cycles forced after each ctrl_valid pulse (must be ≥ worst-case core busy time)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_raw  in  4  raw buttons, bit3 rotate, bit2 left, bit1 down, bit0 right; active-high, asynchronous
gravity_en  in  1  1 = gravity timer runs; 0 = timer held at zero and gravity pending cleared
ctrl_valid  out  1  one-cycle command strobe
ctrl  out  2  command: 11 rotate, 10 left, 01 down, 00 right; holds last value between strobes

Behaviour:
- Reset state (asynchronous): ctrl_valid=0, ctrl=2'b00, all pending flags, counters and FSMs cleared, buttons treated as released. Reset asserted mid-pulse or mid-gap drops ctrl_valid at once and discards all pending requests.
- Per button, synchronizer: 2-FF synchronizer.
- Per button, debounce: a counter counts while the synced value differs from the debounced value. It resets whenever the two match. When the count reaches DEBOUNCE_CYC, the debounced value flips. Any bounce restarts the count.
- Per button, repeat FSM, state RELEASED: on a debounced rising edge, emit an event and go to DELAY.
- Repeat FSM, state DELAY: after REPEAT_DELAY cycles held, emit an event and go to REPEAT.
- Repeat FSM, state REPEAT: emit an event every REPEAT_RATE cycles.
- Repeat FSM: a debounced release in any state returns to RELEASED; no event is emitted on release.
- Rotate never auto-repeats: its FSM stays in a HELD state until release.
- Gravity: a counter runs 0..GRAVITY_CYC-1 while gravity_en=1. At terminal count it sets down-pending and wraps to 0.
- Gravity restart: every issued down command (manual or gravity) restarts the gravity counter at 0.
- Pending flags: one per command, 4 in total; a gravity event and a manual down event merge into the same down flag.
- Event merging: no queuing beyond one per command; an event arriving while its flag is set is absorbed. If an event and the issue of the same flag occur in the same cycle, the flag stays set.
- Issue FSM, state IDLE: if any flag is set, latch ctrl from the highest-priority flag, clear that flag, go to FIRE. Priority: rotate > left > right > down.
- Issue FSM, state FIRE: ctrl_valid=1 for exactly this one cycle; load the gap counter with CMD_GAP; go to GAP.
- Issue FSM, state GAP: decrement the gap counter; at 0 go to IDLE. Result: strobes are at least CMD_GAP+2 cycles apart.
- Latency: from a raw edge that stays stable, with the issue FSM idle, ctrl_valid rises exactly DEBOUNCE_CYC+4 cycles later. The 4 cycles are: 2 sync, 1 debounce register, 1 pending/issue.
- Left and right held together: both produce events; arbitration serializes them, left first.
- Width rule: each counter is $clog2(param+1) bits wide. All comparisons are unsigned and equality-based, so counters never wrap past their parameter value.

Decomposition:
- tetris_pkg: ctrl code enum CTRL_RIGHT=2'b00, CTRL_DOWN=2'b01, CTRL_LEFT=2'b10, CTRL_ROTATE=2'b11; button index constants; issue-FSM state enum.
- Sub-module btn_conditioner: synchronizer, debounce and repeat FSM, with parameter REPEAT_EN. It is instanced 4 times; rotate uses REPEAT_EN=0.
- Gravity counter, pending flags, arbiter and issue FSM stay in the top module.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=8, GRAVITY_CYC=50, CMD_GAP=6.
1. Reset and idle: reset_n=0 → ctrl_valid=0, ctrl=00 immediately. Release reset with gravity_en=0 and buttons idle for 500 cycles → no strobe.
2. Bounce then stable press: left toggles every 2 cycles for 12 cycles → no strobe. Left then held from cycle T → single strobe ctrl=10 at T+8.
3. Auto-repeat: down held → strobes ctrl=01 at t0, t0+20, t0+28, t0+36. Release → strobes stop. Rotate held for 100 cycles → exactly one 11 strobe.
4. Simultaneous press: rotate and right rise in the same cycle → ctrl=11 at t, then ctrl=00 at t+8; ctrl_valid is high for one cycle each.
5. Gravity: gravity_en=1 → ctrl=01 every 52 cycles (50 count, plus 2 issue). A manual down press restarts the interval from its strobe. gravity_en=0 → strobes stop and the counter reads 0.
6. Reset mid-operation: assert reset_n=0 during FIRE with left and down pending → ctrl_valid falls in the same cycle. After release, no stale strobe appears.
